// File: rtl/cpu_pkg.sv
// Shared CPU constants and the return-address-stack operation decode.
// The link/return decode itself lives in the control unit; only the encodings are kept here.
package cpu_pkg;

    localparam logic [5:0] FUNCT_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;
    localparam logic [4:0] REG_RA     = 5'd31;

    localparam int unsigned RAS_DEPTH = 8;
    localparam int unsigned RAS_CW    = 16;

    typedef enum logic [2:0] {
        RAS_IDLE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP,
        RAS_FLUSH
    } ras_op_e;

    // Flush dominates; a simultaneous push and pop becomes a swap.
    function automatic ras_op_e ras_decode(input logic flush, input logic push, input logic pop);
        ras_op_e op;
        if (flush)
            op = RAS_FLUSH;
        else if (push && pop)
            op = RAS_SWAP;
        else if (push)
            op = RAS_PUSH;
        else if (pop)
            op = RAS_POP;
        else
            op = RAS_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/return_addr_stack_sat_counter.sv
// Saturating up-counter used for the return-stack statistics; cleared only by reset.
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [CW-1:0] value
);

    logic [CW-1:0] value_q;
    logic [CW-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1))
            value_d = value_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack: pushes link addresses, pops predicted return
// targets, flags hit/mispredict one cycle after the pop, and keeps statistics.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned CW    = RAS_CW
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       link_valid,
    input  logic [31:0]                link_addr,
    input  logic                       ret_valid,
    input  logic [31:0]                ret_actual,
    output logic [31:0]                pred_target,
    output logic                       pred_valid,
    output logic                       hit,
    output logic                       mispredict,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CW-1:0]              ret_total,
    output logic [CW-1:0]              miss_total
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned NW = PW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] tp_q, tp_d;
    logic [NW-1:0] count_q, count_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          ret_inc;

    ras_op_e       op;
    logic          not_empty;
    logic          top_match;
    logic [PW-1:0] tp_inc;
    logic [PW-1:0] tp_dec;

    assign not_empty = (count_q != '0);
    assign top_match = (mem_q[tp_q] == ret_actual);
    assign tp_inc    = PW'(tp_q + 1'b1);
    assign tp_dec    = PW'(tp_q - 1'b1);

    always_comb begin
        op      = ras_decode(flush, link_valid, ret_valid);
        mem_d   = mem_q;
        tp_d    = tp_q;
        count_d = count_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        ret_inc = 1'b0;
        case (op)
            RAS_FLUSH: begin
                count_d = '0;
            end
            RAS_PUSH: begin
                // Wrap-around overwrites the oldest entry once full.
                mem_d[tp_inc] = link_addr;
                tp_d          = tp_inc;
                if (count_q != NW'(DEPTH))
                    count_d = count_q + 1'b1;
            end
            RAS_POP: begin
                ret_inc = 1'b1;
                if (not_empty) begin
                    hit_d   = top_match;
                    miss_d  = !top_match;
                    tp_d    = tp_dec;
                    count_d = count_q - 1'b1;
                end else begin
                    miss_d  = 1'b1;
                end
            end
            RAS_SWAP: begin
                // Compare against the old top, then replace it in place.
                ret_inc     = 1'b1;
                hit_d       = not_empty && top_match;
                miss_d      = !(not_empty && top_match);
                mem_d[tp_q] = link_addr;
                if (!not_empty)
                    count_d = NW'(1);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            tp_q    <= '0;
            count_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            tp_q    <= tp_d;
            count_q <= count_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    sat_counter #(.CW(CW)) u_ret_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ret_inc),
        .value (ret_total)
    );

    sat_counter #(.CW(CW)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_d),
        .value (miss_total)
    );

    assign pred_target = not_empty ? mem_q[tp_q] : '0;
    assign pred_valid  = not_empty;
    assign hit         = hit_q;
    assign mispredict  = miss_q;
    assign count       = count_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench: stimulus queues the expected hit/mispredict pulse, a negedge
// monitor matches DUT pulses against it; state is checked right after each edge.
module tb_return_addr_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        link_valid = 1'b0;
    logic [31:0] link_addr = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_actual = '0;

    logic [31:0] pred_target;
    logic        pred_valid;
    logic        hit;
    logic        mispredict;
    logic [3:0]  count;
    logic [15:0] ret_total;
    logic [15:0] miss_total;

    logic [31:0] s_pred_target;
    logic        s_pred_valid;
    logic        s_hit;
    logic        s_mispredict;
    logic [3:0]  s_count;
    logic [3:0]  s_ret_total;
    logic [3:0]  s_miss_total;

    return_addr_stack #(.DEPTH(8), .CW(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .link_valid(link_valid), .link_addr(link_addr),
        .ret_valid(ret_valid), .ret_actual(ret_actual),
        .pred_target(pred_target), .pred_valid(pred_valid),
        .hit(hit), .mispredict(mispredict), .count(count),
        .ret_total(ret_total), .miss_total(miss_total)
    );

    return_addr_stack #(.DEPTH(8), .CW(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .link_valid(link_valid), .link_addr(link_addr),
        .ret_valid(ret_valid), .ret_actual(ret_actual),
        .pred_target(s_pred_target), .pred_valid(s_pred_valid),
        .hit(s_hit), .mispredict(s_mispredict), .count(s_count),
        .ret_total(s_ret_total), .miss_total(s_miss_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        bit          hit;
        bit          miss;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                total++;
                bad++;
                $display("FAIL pulse_missing: expected hit=%0d mispredict=%0d at cycle %0d, no pulse observed",
                         e.hit, e.miss, e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                total++;
                if (hit !== e.hit || mispredict !== e.miss) begin
                    bad++;
                    $display("FAIL pulse cycle %0d: got hit=%0d mispredict=%0d want hit=%0d mispredict=%0d",
                             cyc, hit, mispredict, e.hit, e.miss);
                end
            end else begin
                total++;
                if (hit !== 1'b0 || mispredict !== 1'b0) begin
                    bad++;
                    $display("FAIL quiet cycle %0d: got hit=%0d mispredict=%0d want 0 0",
                             cyc, hit, mispredict);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic do_op(input bit ps, input logic [31:0] la, input bit pp,
                         input logic [31:0] ra, input bit fl, input bit eh, input bit em);
        exp_t e;
        @(negedge clk);
        link_valid = ps;
        link_addr  = la;
        ret_valid  = pp;
        ret_actual = ra;
        flush      = fl;
        if (pp && !fl) begin
            e.cyc  = cyc + 1;
            e.hit  = eh;
            e.miss = em;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        link_valid = 1'b0;
        ret_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic push(input logic [31:0] a);
        do_op(1'b1, a, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [31:0] ra, input bit eh);
        do_op(1'b0, '0, 1'b1, ra, 1'b0, eh, !eh);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_pred_valid", 32'(pred_valid), 0);
        chk("reset_pred_target", pred_target, 0);
        chk("reset_ret_total", 32'(ret_total), 0);
        chk("reset_miss_total", 32'(miss_total), 0);
        chk("reset_hit", 32'(hit), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic match
        push(32'h0040_0010);
        chk("basic_pred_target", pred_target, 32'h0040_0010);
        chk("basic_pred_valid", 32'(pred_valid), 1);
        chk("basic_count1", 32'(count), 1);
        pop(32'h0040_0010, 1'b1);
        chk("basic_count0", 32'(count), 0);
        chk("basic_ret_total", 32'(ret_total), 1);
        chk("basic_miss_total", 32'(miss_total), 0);

        // Mismatch then underflow
        push(32'h100);
        pop(32'h104, 1'b0);
        pop(32'h0, 1'b0);
        chk("mm_count", 32'(count), 0);
        chk("mm_miss_total", 32'(miss_total), 2);
        chk("mm_pred_target", pred_target, 0);
        chk("mm_ret_total", 32'(ret_total), 3);

        // Wrap-around: nine pushes into eight entries
        for (int i = 1; i <= 9; i++) push(32'(i * 16));
        chk("wrap_count", 32'(count), 8);
        chk("wrap_pred_target", pred_target, 32'h90);
        for (int i = 9; i >= 2; i--) pop(32'(i * 16), 1'b1);
        chk("wrap_count_empty", 32'(count), 0);
        pop(32'h10, 1'b0);
        chk("wrap_ret_total", 32'(ret_total), 12);
        chk("wrap_miss_total", 32'(miss_total), 3);

        // Simultaneous push and pop
        push(32'hA0);
        push(32'hB0);
        do_op(1'b1, 32'hC0, 1'b1, 32'hB0, 1'b0, 1'b1, 1'b0);
        chk("swap_count", 32'(count), 2);
        chk("swap_pred_target", pred_target, 32'hC0);
        pop(32'hC0, 1'b1);
        pop(32'hA0, 1'b1);
        do_op(1'b1, 32'hC0, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b1);
        chk("swap_empty_count", 32'(count), 1);
        chk("swap_empty_pred_target", pred_target, 32'hC0);
        chk("swap_ret_total", 32'(ret_total), 16);
        chk("swap_miss_total", 32'(miss_total), 4);

        // Flush priority with three entries
        push(32'h1);
        push(32'h2);
        chk("flush_pre_count", 32'(count), 3);
        do_op(1'b1, 32'hD0, 1'b1, 32'h2, 1'b1, 1'b0, 1'b0);
        chk("flush_count", 32'(count), 0);
        chk("flush_pred_valid", 32'(pred_valid), 0);
        chk("flush_ret_total", 32'(ret_total), 16);
        chk("flush_miss_total", 32'(miss_total), 4);

        // Async reset drops a pending hit pulse
        push(32'h55);
        push(32'h66);
        @(negedge clk);
        ret_valid  = 1'b1;
        ret_actual = 32'h66;
        @(posedge clk);
        #1;
        ret_valid = 1'b0;
        chk("areset_pulse_before", 32'(hit), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_hit", 32'(hit), 0);
        chk("areset_count", 32'(count), 0);
        chk("areset_pred_valid", 32'(pred_valid), 0);
        chk("areset_pred_target", pred_target, 0);
        chk("areset_ret_total", 32'(ret_total), 0);
        chk("areset_miss_total", 32'(miss_total), 0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation: twenty underflow pops
        for (int i = 0; i < 20; i++) pop(32'h0, 1'b0);
        chk("sat_miss_total", 32'(s_miss_total), 15);
        chk("sat_ret_total", 32'(s_ret_total), 15);
        chk("nosat_miss_total", 32'(miss_total), 20);
        chk("nosat_ret_total", 32'(ret_total), 20);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Return-address stack that sits in the fetch/PC-select path. It is the write side of the jump-register path: each retiring JAL/JALR pushes its link address (PC+4), and each retiring `jr $31` pops the top entry as the predicted return target. The popped entry is compared against the architectural register value and the block flags hits and mispredicts. It also keeps saturating statistics counters for performance monitoring.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, at least 2.
- CW, 16: width of each statistics counter.

Ports (all widths in bits):
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- flush, input, 1: synchronous clear of the stack (exception or context switch).
- link_valid, input, 1: a JAL/JALR retires this cycle; push.
- link_addr, input, 32: PC+4 of the linking instruction.
- ret_valid, input, 1: a JR with rs=$31 (funct 6'b001000) retires this cycle; pop.
- ret_actual, input, 32: RD1, the architectural $31 value used by the JR.
- pred_target, output, 32: top-of-stack entry; 0 when empty.
- pred_valid, output, 1: stack is non-empty.
- hit, output, 1: registered one-cycle pulse, popped entry equals ret_actual.
- mispredict, output, 1: registered one-cycle pulse, entry mismatched or the stack was empty.
- count, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- ret_total, output, CW: saturating count of pops.
- miss_total, output, CW: saturating count of mispredicts.

## Operation
- Storage is a circular buffer of DEPTH×32 with top pointer `tp` (log2 DEPTH bits) and `count`.
- **Push only:** write link_addr at tp+1 mod DEPTH, tp←tp+1. count←min(count+1, DEPTH). At DEPTH the oldest entry is silently overwritten (wrap-around). count stays DEPTH and there is no error.
- **Pop only, count>0:** compare entry[tp] with ret_actual and set hit or mispredict. tp←tp−1 mod DEPTH, count←count−1.
- **Pop only, count==0 (underflow):** mispredict=1, hit=0. tp and count unchanged.
- **Push and pop in the same cycle** (e.g. `jalr $31,$31`): compare against the old top first, then overwrite entry[tp] with link_addr.
  - tp is unchanged.
  - count is unchanged if count>0, else it becomes 1 with the entry written at tp.
- **flush:** count←0. tp is unchanged. Any push or pop in the same cycle is ignored, and no hit or mispredict is raised. flush has priority over everything except reset.
- **Statistics:**
  - ret_total increments on every accepted pop (not during flush).
  - miss_total increments with every mispredict.
  - Both saturate at 2^CW−1 and are cleared only by reset.
- **Prediction outputs:** pred_target and pred_valid are combinational from the registered tp and count, with no dependency on the current-cycle inputs.

## Timing
- **Reset values:**
  - tp=0, count=0, all entries 0.
  - hit=0, mispredict=0.
  - ret_total=0, miss_total=0.
  - pred_target=0, pred_valid=0.
- **Push/pop latency:** one cycle. The new top appears on pred_target in the cycle after the edge that sampled link_valid or ret_valid.
- **hit/mispredict:** asserted for exactly the one cycle after the sampling edge, and never both at once. Back-to-back pops give back-to-back pulses.
- **Reset mid-operation:** reset asserted at any time clears state immediately, without waiting for clk. A pending pulse is dropped.
- **Inputs:** no handshake and no backpressure; the block accepts every cycle.

## Structure
- Shared package `cpu_pkg` holds:
  - FUNCT_JR=6'b001000, OP_JAL=6'b000011, FUNCT_JALR=6'b001001, REG_RA=5'd31;
  - the default RAS_DEPTH.
- The decode of link_valid and ret_valid lives in the control unit, not in this block.
- One sub-module, `sat_counter` (parameter CW; ports inc, clear-on-reset, value), instantiated twice for the statistics.

## Test plan
- **Basic match:** reset, push 0x0040_0010, then pop with ret_actual=0x0040_0010.
  - Before the pop: pred_target=0x0040_0010, pred_valid=1.
  - After the pop: hit pulses for one cycle; count 1→0; ret_total=1, miss_total=0.
- **Mismatch and underflow:** push 0x100, then pop with ret_actual=0x104, then pop again with the stack empty.
  - Each pop gives a mispredict pulse.
  - Final state: count=0, miss_total=2, pred_target=0.
- **Wrap-around (DEPTH=8):** push 0x10,0x20,…,0x90 (9 pushes).
  - count=8 and pred_target=0x90.
  - Eight matching pops give hits for 0x90 down to 0x20.
  - A ninth pop gives mispredict (0x10 was lost).
- **Simultaneous push/pop:** stack holds [0xA0,0xB0 top]. Assert push 0xC0 with pop, ret_actual=0xB0.
  - hit pulses; count stays 2; pred_target=0xC0.
  - Repeat from an empty stack: mispredict pulses, count=1, pred_target=0xC0.
- **Flush priority:** with 3 entries, assert flush together with push 0xD0 and a pop.
  - count=0, pred_valid=0.
  - No hit or mispredict; ret_total unchanged.
- **Async reset and saturation:**
  - Assert reset between clock edges mid-sequence: all outputs read 0 before the next edge.
  - With CW=4, apply 20 mispredicting pops: miss_total and ret_total hold at 15.
